// File: rtl/nes_mem_pkg.sv
// Shared state encoding, bus widths and default timing for the flash-to-PSRAM loader.
package nes_mem_pkg;

  typedef enum logic [2:0] {
    FRST   = 3'd0,
    FWAIT  = 3'd1,
    FREAD  = 3'd2,
    PWRITE = 3'd3,
    PGAP   = 3'd4,
    DONE   = 3'd5
  } ld_state_t;

  localparam int ADDR_W = 23;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 15;
  localparam int CNT_W  = 16;

  localparam int DEF_WORDS      = 20480;
  localparam int DEF_FLASH_WAIT = 6;
  localparam int DEF_PSRAM_WAIT = 4;
  localparam int DEF_RST_CYC    = 16;

  // Everything the loader drives onto the shared bus, registered as one word.
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d_out;
    logic              d_oe;
    logic              oe_n;
    logic              we_n;
    logic              flash_ce_n;
    logic              psram_ce_n;
    logic              flash_reset_n;
    logic              busy;
    logic              done;
  } bus_t;

  localparam bus_t BUS_RST = '{
    a:             23'h000000,
    d_out:         16'h0000,
    d_oe:          1'b0,
    oe_n:          1'b1,
    we_n:          1'b1,
    flash_ce_n:    1'b1,
    psram_ce_n:    1'b1,
    flash_reset_n: 1'b0,
    busy:          1'b1,
    done:          1'b0
  };

  // Counter load value that makes a state last cyc cycles.
  function automatic logic [CNT_W-1:0] dwell_ld(input int cyc);
    return CNT_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Down-counter timing FSM dwell periods: load N-1 on entry, zero flags the last cycle.
// Load takes effect on the next clock; holds at zero until reloaded.
module wait_counter #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/flash_psram_loader.sv
// Copies WORDS 16-bit words from parallel flash to async PSRAM over a shared bus after reset.
// Bus outputs are registered from the next state, so strobes change cleanly on clock edges.
module flash_psram_loader
  import nes_mem_pkg::*;
#(
  parameter int                WORDS      = DEF_WORDS,
  parameter logic [ADDR_W-1:0] SRC_BASE   = 23'h000000,
  parameter logic [ADDR_W-1:0] DST_BASE   = 23'h000000,
  parameter int                FLASH_WAIT = DEF_FLASH_WAIT,
  parameter int                PSRAM_WAIT = DEF_PSRAM_WAIT,
  parameter int                RST_CYC    = DEF_RST_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] shared_a,
  input  logic [DATA_W-1:0] shared_d_in,
  output logic [DATA_W-1:0] shared_d_out,
  output logic              shared_d_oe,
  output logic              shared_oe_n,
  output logic              shared_we_n,
  output logic              flash_ce_n,
  output logic              psram_ce_n,
  output logic              flash_reset_n,
  output logic              shared_adv_n,
  output logic              psram_cre,
  output logic              shared_clk,
  output logic              psram_lb_n,
  output logic              psram_ub_n,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] RST_LD   = dwell_ld(RST_CYC);
  localparam logic [CNT_W-1:0] FW_LD    = dwell_ld(FLASH_WAIT);
  localparam logic [CNT_W-1:0] PW_LD    = dwell_ld(PSRAM_WAIT);

  ld_state_t         state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [DATA_W-1:0] data, data_nxt;
  bus_t              bus;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_val;
  logic              cnt_zero;

  wait_counter #(
    .W       (CNT_W),
    .RST_VAL (RST_LD)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FRST;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    data_nxt  = data;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    case (state)
      FRST: if (cnt_zero) begin
        state_nxt = FWAIT;
        cnt_load  = 1'b1;
        cnt_val   = RST_LD;
      end
      FWAIT: if (cnt_zero) begin
        state_nxt = FREAD;
        idx_nxt   = '0;
        cnt_load  = 1'b1;
        cnt_val   = FW_LD;
      end
      FREAD: if (cnt_zero) begin
        state_nxt = PWRITE;
        data_nxt  = shared_d_in;
        cnt_load  = 1'b1;
        cnt_val   = PW_LD;
      end
      PWRITE: if (cnt_zero) begin
        state_nxt = PGAP;
        cnt_load  = 1'b1;
        cnt_val   = '0;
      end
      PGAP: begin
        cnt_load = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          state_nxt = FREAD;
          idx_nxt   = idx + 1'b1;
          cnt_val   = FW_LD;
        end
      end
      DONE: if (start) begin
        state_nxt = FREAD;
        idx_nxt   = '0;
        cnt_load  = 1'b1;
        cnt_val   = FW_LD;
      end
      default: state_nxt = FRST;
    endcase
  end

  // Strobes are a pure function of state, so FREAD and PWRITE can never overlap on the bus.
  function automatic bus_t decode(input ld_state_t st, input logic [IDX_W-1:0] ix,
                                  input logic [DATA_W-1:0] dat);
    bus_t b;
    b               = BUS_RST;
    b.flash_reset_n = (st != FRST);
    b.busy          = (st != DONE);
    b.done          = (st == DONE);
    case (st)
      FREAD: begin
        b.flash_ce_n = 1'b0;
        b.oe_n       = 1'b0;
        b.a          = SRC_BASE + {{(ADDR_W-IDX_W){1'b0}}, ix};
      end
      PWRITE: begin
        b.psram_ce_n = 1'b0;
        b.we_n       = 1'b0;
        b.d_oe       = 1'b1;
        b.d_out      = dat;
        b.a          = DST_BASE + {{(ADDR_W-IDX_W){1'b0}}, ix};
      end
      default: ;
    endcase
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      data <= '0;
      bus  <= BUS_RST;
    end else begin
      idx  <= idx_nxt;
      data <= data_nxt;
      bus  <= decode(state_nxt, idx_nxt, data_nxt);
    end
  end

  assign shared_a      = bus.a;
  assign shared_d_out  = bus.d_out;
  assign shared_d_oe   = bus.d_oe;
  assign shared_oe_n   = bus.oe_n;
  assign shared_we_n   = bus.we_n;
  assign flash_ce_n    = bus.flash_ce_n;
  assign psram_ce_n    = bus.psram_ce_n;
  assign flash_reset_n = bus.flash_reset_n;
  assign busy          = bus.busy;
  assign done          = bus.done;

  // Asynchronous PSRAM mode, both byte lanes always enabled.
  assign shared_adv_n  = 1'b0;
  assign psram_cre     = 1'b0;
  assign shared_clk    = 1'b0;
  assign psram_lb_n    = 1'b0;
  assign psram_ub_n    = 1'b0;

endmodule

// File: tb/tb_flash_psram_loader.sv
// Scoreboard bench: two loader instances (default and fast timing) against flash/PSRAM models.
module tb_flash_psram_loader;

  localparam logic [22:0] SRC_A = 23'h000000;
  localparam logic [22:0] DST_A = 23'h000040;
  localparam logic [22:0] SRC_B = 23'h7FFFFE;
  localparam logic [22:0] DST_B = 23'h000100;

  typedef struct packed {
    logic [22:0] a;
    logic [15:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] flash_val(input logic [22:0] ad);
    case (ad)
      23'd0:   return 16'h1234;
      23'd1:   return 16'h5678;
      23'd2:   return 16'h9ABC;
      23'd3:   return 16'hDEF0;
      default: return {ad[7:0], ~ad[7:0]};
    endcase
  endfunction

  // ---------------- instance A: default timing, WORDS=4 ----------------
  logic        rst_a_n, start_a;
  logic [22:0] a_a;
  logic [15:0] din_a, dout_a;
  logic        doe_a, oe_a, we_a, fce_a, pce_a, frst_a;
  logic        adv_a, cre_a, sclk_a, lb_a, ub_a, busy_a, done_a;

  assign din_a = (!fce_a && !oe_a) ? flash_val(a_a) : 16'h0BAD;

  flash_psram_loader #(
    .WORDS(4), .SRC_BASE(SRC_A), .DST_BASE(DST_A)
  ) dut_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .shared_a(a_a),
    .shared_d_in(din_a), .shared_d_out(dout_a), .shared_d_oe(doe_a),
    .shared_oe_n(oe_a), .shared_we_n(we_a), .flash_ce_n(fce_a), .psram_ce_n(pce_a),
    .flash_reset_n(frst_a), .shared_adv_n(adv_a), .psram_cre(cre_a),
    .shared_clk(sclk_a), .psram_lb_n(lb_a), .psram_ub_n(ub_a),
    .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: wrapping source, 1-cycle waits ----------------
  logic        rst_b_n, start_b;
  logic [22:0] a_b;
  logic [15:0] din_b, dout_b;
  logic        doe_b, oe_b, we_b, fce_b, pce_b, frst_b;
  logic        adv_b, cre_b, sclk_b, lb_b, ub_b, busy_b, done_b;

  assign din_b = (!fce_b && !oe_b) ? flash_val(a_b) : 16'h0BAD;

  flash_psram_loader #(
    .WORDS(4), .SRC_BASE(SRC_B), .DST_BASE(DST_B), .FLASH_WAIT(1), .PSRAM_WAIT(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_b_n), .start(start_b), .shared_a(a_b),
    .shared_d_in(din_b), .shared_d_out(dout_b), .shared_d_oe(doe_b),
    .shared_oe_n(oe_b), .shared_we_n(we_b), .flash_ce_n(fce_b), .psram_ce_n(pce_b),
    .flash_reset_n(frst_b), .shared_adv_n(adv_b), .psram_cre(cre_b),
    .shared_clk(sclk_b), .psram_lb_n(lb_b), .psram_ub_n(ub_b),
    .busy(busy_b), .done(done_b)
  );

  // ---------------- scoreboards and bus monitors ----------------
  wr_t         exp_wr_a[$], exp_wr_b[$];
  logic [22:0] exp_rd_a[$], exp_rd_b[$];
  logic [15:0] pmem_a[logic [22:0]];
  logic [15:0] pmem_b[logic [22:0]];
  int   both_ce_a = 0, clash_a = 0, both_ce_b = 0, clash_b = 0;
  int   last_wr_a = 0, last_wr_b = 0;
  logic wr_prev_a = 1'b0, rd_prev_a = 1'b0, wr_prev_b = 1'b0, rd_prev_b = 1'b0;

  always @(negedge clk) begin
    wr_t e;
    logic first;
    if (!fce_a && !pce_a) both_ce_a++;
    if (doe_a && !oe_a) clash_a++;
    if (!fce_a && !oe_a && !rd_prev_a) begin
      if (exp_rd_a.size() == 0) check("a_rd_unexpected", {9'd0, a_a}, 32'hFFFFFFFF);
      else check("a_rd_addr", {9'd0, a_a}, {9'd0, exp_rd_a.pop_front()});
    end
    if (!pce_a && !we_a) begin
      pmem_a[a_a] = dout_a;
      if (!wr_prev_a) begin
        if (exp_wr_a.size() == 0) check("a_wr_unexpected", {9'd0, a_a}, 32'hFFFFFFFF);
        else begin
          first = (exp_wr_a.size() == 4);
          e = exp_wr_a.pop_front();
          check("a_wr_addr", {9'd0, a_a}, {9'd0, e.a});
          check("a_wr_data", {16'd0, dout_a}, {16'd0, e.d});
          if (!first) check("a_word_cycles", cyc - last_wr_a, 11);
          last_wr_a = cyc;
        end
      end
    end
    rd_prev_a = !fce_a && !oe_a;
    wr_prev_a = !pce_a && !we_a;
  end

  always @(negedge clk) begin
    wr_t e;
    logic first;
    if (!fce_b && !pce_b) both_ce_b++;
    if (doe_b && !oe_b) clash_b++;
    if (!fce_b && !oe_b && !rd_prev_b) begin
      if (exp_rd_b.size() == 0) check("b_rd_unexpected", {9'd0, a_b}, 32'hFFFFFFFF);
      else check("b_rd_addr", {9'd0, a_b}, {9'd0, exp_rd_b.pop_front()});
    end
    if (!pce_b && !we_b) begin
      pmem_b[a_b] = dout_b;
      if (!wr_prev_b) begin
        if (exp_wr_b.size() == 0) check("b_wr_unexpected", {9'd0, a_b}, 32'hFFFFFFFF);
        else begin
          first = (exp_wr_b.size() == 4);
          e = exp_wr_b.pop_front();
          check("b_wr_addr", {9'd0, a_b}, {9'd0, e.a});
          check("b_wr_data", {16'd0, dout_b}, {16'd0, e.d});
          if (!first) check("b_word_cycles", cyc - last_wr_b, 3);
          last_wr_b = cyc;
        end
      end
    end
    rd_prev_b = !fce_b && !oe_b;
    wr_prev_b = !pce_b && !we_b;
  end

  task automatic push_a();
    for (int i = 0; i < 4; i++) begin
      exp_rd_a.push_back(SRC_A + 23'(i));
      exp_wr_a.push_back('{a: DST_A + 23'(i), d: flash_val(SRC_A + 23'(i))});
    end
  endtask

  task automatic push_b();
    for (int i = 0; i < 4; i++) begin
      exp_rd_b.push_back(SRC_B + 23'(i));
      exp_wr_b.push_back('{a: DST_B + 23'(i), d: flash_val(SRC_B + 23'(i))});
    end
  endtask

  function automatic logic [31:0] pget_a(input logic [22:0] k);
    return pmem_a.exists(k) ? {16'd0, pmem_a[k]} : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] pget_b(input logic [22:0] k);
    return pmem_b.exists(k) ? {16'd0, pmem_b[k]} : 32'hDEADBEEF;
  endfunction

  // Counts edges until done, optionally pulsing start after edge start_at.
  task automatic wait_done_a(input int start_at, output int n, output logic saw_frst_low);
    n = 0;
    saw_frst_low = 1'b0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      start_a = (n == start_at);
      if (!frst_a) saw_frst_low = 1'b1;
      if (done_a) break;
    end
    start_a = 1'b0;
    if (n >= 3000) check("a_done_timeout", n, 0);
  endtask

  task automatic wait_done_b(output int n);
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      n++;
      #1;
      if (done_b) break;
    end
    if (n >= 3000) check("b_done_timeout", n, 0);
  endtask

  initial begin
    int   n;
    logic low;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy_a}, 1);
    check("rst_done", {31'd0, done_a}, 0);
    check("rst_flash_reset_n", {31'd0, frst_a}, 0);
    check("rst_strobes", {28'd0, oe_a, we_a, fce_a, pce_a}, 32'hF);
    check("rst_d_oe", {31'd0, doe_a}, 0);
    check("rst_addr", {9'd0, a_a}, 0);
    check("const_pins", {27'd0, adv_a, cre_a, sclk_a, lb_a, ub_a}, 0);

    // Fast copy with a source range that wraps past the top of the address space.
    push_b();
    @(negedge clk);
    rst_b_n = 1'b1;
    wait_done_b(n);
    check("b_done_latency", n, 2 * 16 + 4 * 3);
    check("b_busy_in_done", {31'd0, busy_b}, 0);
    check("b_sb_left", exp_wr_b.size() + exp_rd_b.size(), 0);
    for (int i = 0; i < 4; i++)
      check("b_psram_word", pget_b(DST_B + 23'(i)), {16'd0, flash_val(SRC_B + 23'(i))});
    check("b_const_pins", {27'd0, adv_b, cre_b, sclk_b, lb_b, ub_b}, 0);

    // Power-on copy; a start pulse mid-copy must change nothing.
    push_a();
    @(negedge clk);
    rst_a_n = 1'b1;
    wait_done_a(40, n, low);
    check("a_done_latency", n, 2 * 16 + 4 * 11);
    check("a_sb_left", exp_wr_a.size() + exp_rd_a.size(), 0);
    for (int i = 0; i < 4; i++)
      check("a_psram_word", pget_a(DST_A + 23'(i)), {16'd0, flash_val(SRC_A + 23'(i))});

    // Re-copy from DONE: no flash reset this time.
    repeat (3) @(posedge clk);
    #1;
    check("a_done_holds", {31'd0, done_a}, 1);
    push_a();
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    check("a_done_falls", {31'd0, done_a}, 0);
    check("a_busy_rises", {31'd0, busy_a}, 1);
    wait_done_a(-1, n, low);
    check("a_recopy_latency", n, 4 * 11);
    check("a_recopy_no_flash_reset", {31'd0, low}, 0);
    check("a_sb_left2", exp_wr_a.size() + exp_rd_a.size(), 0);

    // Reset during word 2 of a re-copy.
    pmem_a.delete();
    push_a();
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    n = 0;
    while (n < 500 && !(!fce_a && a_a == SRC_A + 23'd1)) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("a_reached_word2", {31'd0, n < 500}, 1);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy_a}, 1);
    check("abort_done", {31'd0, done_a}, 0);
    check("abort_flash_reset_n", {31'd0, frst_a}, 0);
    check("abort_strobes", {28'd0, oe_a, we_a, fce_a, pce_a}, 32'hF);
    check("abort_d_oe", {31'd0, doe_a}, 0);
    check("abort_addr", {9'd0, a_a}, 0);
    exp_wr_a.delete();
    exp_rd_a.delete();
    repeat (2) @(posedge clk);
    push_a();
    @(negedge clk);
    rst_a_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_flash_reset_n", {31'd0, frst_a}, 0);
    wait_done_a(-1, n, low);
    check("restart_latency", n, 2 * 16 + 4 * 11 - 1);
    check("a_sb_left3", exp_wr_a.size() + exp_rd_a.size(), 0);
    for (int i = 0; i < 4; i++)
      check("restart_psram_word", pget_a(DST_A + 23'(i)), {16'd0, flash_val(SRC_A + 23'(i))});

    repeat (5) @(posedge clk);
    #1;
    check("a_both_ce_low", both_ce_a, 0);
    check("a_doe_vs_oe", clash_a, 0);
    check("b_both_ce_low", both_ce_b, 0);
    check("b_doe_vs_oe", clash_b, 0);
    check("a_sb_final", exp_wr_a.size() + exp_rd_a.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
